// File: rtl/seq_mult_pkg.sv
// seq_mult shared types and defaults.
// Imported by seq_mult and seq_mult_step.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

    localparam int SEQ_MULT_DEFAULT_N = 32;

endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one shift-and-add iteration.
// acc layout is {carry, hi, lo}; carry is always 0 on entry.
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int N = SEQ_MULT_DEFAULT_N
) (
    input  logic [2*N:0]   acc,
    input  logic [N-1:0]   mcand,
    output logic [2*N:0]   nxt
);

    logic [N:0] sum;

    always_comb begin
        sum = acc[2*N:N];
        if (acc[0]) begin
            sum = acc[2*N:N] + {1'b0, mcand};
        end
        nxt = {1'b0, sum, acc[N-1:1]};
    end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: iterative N-cycle shift-and-add multiplier.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int N = SEQ_MULT_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    seq_mult_state_t state;

    logic [2*N:0]   acc;
    logic [2*N:0]   nxt;
    logic [N-1:0]   mcand;
    logic [CW-1:0]  count;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] res;

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;

    // Magnitudes; the most negative value maps onto 2^(N-1) unsigned.
    assign a_mag = a_in[N-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag = b_in[N-1] ? (~b_in + 1'b1) : b_in;
    assign res   = neg ? (~nxt[2*N-1:0] + 1'b1) : nxt[2*N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (state == IDLE && start) begin
            neg <= a_in[N-1] ^ b_in[N-1];
        end
    end
`else
    assign a_mag = a_in;
    assign b_mag = b_in;
    assign res   = nxt[2*N-1:0];
`endif

    seq_mult_step #(
        .N(N)
    ) u_step (
        .acc  (acc),
        .mcand(mcand),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {{(N+1){1'b0}}, b_mag};
                        count <= CNT_N;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= nxt;
                    count <= count - 1'b1;
                    if (count == CNT_ONE) begin
                        product <= res;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized and directed checks of seq_mult, N = 8.
// Reference products come from plain integer multiplication.
module tb_seq_mult;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    bit run_clk;
    int checks;
    int errors;
    logic [2*N-1:0] last;

    seq_mult #(
        .N(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a,
                                               input logic [N-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
        int sa = $signed(a);
        int sb = $signed(b);
        ref_mul = 16'(sa * sb);
`else
        ref_mul = 16'(int'(a) * int'(b));
`endif
    endfunction

    // Starts one op; optionally pulses a stray start at RUN cycle stray_at.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input int stray_at);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
        for (int k = 1; k <= N; k++) begin
            start = (k == stray_at);
            if (k == stray_at) begin
                a_in = a + 8'd1;
                b_in = b ^ 8'h5a;
            end
            @(posedge clk);
            #1;
            if (k < N) begin
                check("held", product, last);
                check("done_early", done, 0);
                check("busy_run", busy, 1);
            end else begin
                check("product", product, exp);
                check("done", done, 1);
                check("busy_done", busy, 1);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("busy_off", busy, 0);
        check("product_hold", product, exp);
        last = exp;
    endtask

    initial begin
        clk     = 1'b0;
        run_clk = 1'b0;
        rst_n   = 1'b1;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        checks  = 0;
        errors  = 0;
        last    = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        run_clk = 1'b1;
        #22 rst_n = 1'b1;

        do_op(8'd13, 8'd11, 16'h008F, 0);
`ifdef SEQ_MULT_SIGNED_EN
        do_op(8'hFD, 8'd5, 16'hFFF1, 0);
        do_op(8'h80, 8'h80, 16'h4000, 0);
        do_op(8'd127, 8'hFF, 16'hFF81, 0);
        do_op(8'hFF, 8'hFF, 16'h0001, 0);
`else
        do_op(8'd255, 8'd255, 16'hFE01, 0);
`endif
        do_op(8'd0, 8'd200, 16'h0000, 0);
        do_op(8'd9, 8'd7, ref_mul(8'd9, 8'd7), 3);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd77;
        b_in  = 8'd99;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_product", product, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last  = '0;
        @(posedge clk);
        #1;
        check("idle_after_rst", busy, 0);
        do_op(8'd6, 8'd7, 16'h002A, 0);

        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            rb = N'($urandom);
            if (i == 0) ra = 8'h80;
            if (i == 1) rb = 8'h00;
            do_op(ra, rb, ref_mul(ra, rb), (i % 3 == 0) ? 5 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
